// File: rtl/execute_writeback.sv
// execute_writeback: single-cycle ALU plus 32-step shift-add MUL driving the register-file writeback port.
module execute_writeback #(
    parameter int WORD  = 32,
    parameter int W_OPC = 7,
    parameter int W_RD  = 4,
    parameter int W_OPR = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic [W_OPC-1:0] opecode_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic [W_RD-1:0]  wb_r_i,
    output logic             stall_o,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic [W_OPR-1:0] result_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [W_OPC-1:0] OP_MUL = W_OPC'(9);
    localparam logic [W_OPC-1:0] OP_SLT = W_OPC'(10);
    localparam int SHW = $clog2(WORD);

    logic [0:0]       state_q, state_d;
    logic [W_OPR-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, result_q, result_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [W_RD-1:0]  rd_q, rd_d, wb_r_q, wb_r_d;
    logic             wb_q, wb_d;
    logic [W_OPR-1:0] alu, acc_step;
    logic [SHW-1:0]   sh;

    assign sh       = opr1_i[SHW-1:0];
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu = '0;
        case (opecode_i)
            W_OPC'(0):  alu = opr0_i + opr1_i;
            W_OPC'(1):  alu = opr0_i - opr1_i;
            W_OPC'(2):  alu = opr0_i & opr1_i;
            W_OPC'(3):  alu = opr0_i | opr1_i;
            W_OPC'(4):  alu = opr0_i ^ opr1_i;
            W_OPC'(5):  alu = opr0_i << sh;
            W_OPC'(6):  alu = opr0_i >> sh;
            W_OPC'(7):  alu = $signed(opr0_i) >>> sh;
            W_OPC'(8):  alu = opr1_i;
            OP_SLT:     alu = {{(W_OPR-1){1'b0}}, $signed(opr0_i) < $signed(opr1_i)};
            default:    alu = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wb_d     = 1'b0;
        wb_r_d   = wb_r_q;
        result_d = result_q;
        if (state_q == BUSY) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_d  = IDLE;
                wb_d     = 1'b1;
                wb_r_d   = rd_q;
                result_d = acc_step;
            end
        end else if (v_i) begin
            if (opecode_i == OP_MUL) begin
                mcand_d  = opr0_i;
                mplier_d = opr1_i;
                rd_d     = wb_r_i;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = BUSY;
            end else if (opecode_i <= OP_SLT) begin
                wb_d     = 1'b1;
                wb_r_d   = wb_r_i;
                result_d = alu;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            wb_r_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            wb_r_q   <= wb_r_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = (state_q == BUSY);
    assign wb_o     = wb_q;
    assign wb_r_o   = wb_r_q;
    assign result_o = result_q;
endmodule

// File: tb/tb_execute_writeback.sv
// tb_execute_writeback: directed vectors; expected writebacks queued at issue, popped by a negedge monitor.
module tb_execute_writeback;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v_i = 1'b0;
    logic [6:0]  opecode_i = '0;
    logic [31:0] opr0_i = '0, opr1_i = '0;
    logic [3:0]  wb_r_i = '0;
    logic        stall_o, wb_o;
    logic [3:0]  wb_r_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];
    logic [35:0] e;

    execute_writeback dut (
        .clk(clk), .reset(reset), .v_i(v_i), .opecode_i(opecode_i),
        .opr0_i(opr0_i), .opr1_i(opr1_i), .wb_r_i(wb_r_i),
        .stall_o(stall_o), .wb_o(wb_o), .wb_r_o(wb_r_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wb: got r%0d=%h, required no writeback", wb_r_o, result_o);
            end else begin
                e = exp_q.pop_front();
                if ({wb_r_o, result_o} !== e || stall_o) begin
                    errors++;
                    $display("FAIL wb: got r%0d=%h stall=%b, required r%0d=%h stall=0",
                             wb_r_o, result_o, stall_o, e[35:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd);
        v_i = 1'b1; opecode_i = op; opr0_i = a; opr1_i = b; wb_r_i = rd;
        cyc();
    endtask

    task automatic wait_mul(input string name);
        int n = 0;
        while (stall_o && n < 40) begin
            n++;
            cyc();
        end
        chk(name, 64'(n), 64'd32);
    endtask

    initial begin
        // Reset held with a live ADD on the inputs
        v_i = 1'b1; opecode_i = 7'h00; opr0_i = 5; opr1_i = 7; wb_r_i = 3;
        repeat (3) begin
            cyc();
            chk("reset_outs", {stall_o, wb_o, wb_r_o, result_o}, 64'd0);
        end
        reset = 1'b1; v_i = 1'b0;
        cyc();

        exp_q.push_back({4'd3, 32'd12});
        issue(7'h00, 32'd5, 32'd7, 4'd3);
        chk("bb_wb_add", 64'(wb_o), 64'd1);
        exp_q.push_back({4'd4, 32'hF8000000});
        issue(7'h07, 32'h80000000, 32'd4, 4'd4);
        chk("bb_wb_sra", 64'(wb_o), 64'd1);
        exp_q.push_back({4'd5, 32'd1});
        issue(7'h0A, 32'hFFFFFFFF, 32'd1, 4'd5);
        chk("bb_wb_slt", 64'(wb_o), 64'd1);
        exp_q.push_back({4'd1, 32'hFFFFFFFE}); issue(7'h01, 32'd3, 32'd5, 4'd1);
        exp_q.push_back({4'd2, 32'h0000F000}); issue(7'h02, 32'h0000F0F0, 32'h0000FF00, 4'd2);
        exp_q.push_back({4'd3, 32'h0000FFF0}); issue(7'h03, 32'h0000F0F0, 32'h0000FF00, 4'd3);
        exp_q.push_back({4'd4, 32'h00000FF0}); issue(7'h04, 32'h0000F0F0, 32'h0000FF00, 4'd4);
        exp_q.push_back({4'd5, 32'd2});        issue(7'h05, 32'd1, 32'd33, 4'd5);
        exp_q.push_back({4'd6, 32'd1});        issue(7'h06, 32'h80000000, 32'd31, 4'd6);
        exp_q.push_back({4'd7, 32'hDEADBEEF}); issue(7'h08, 32'd9, 32'hDEADBEEF, 4'd7);
        exp_q.push_back({4'd8, 32'd0});        issue(7'h0A, 32'd1, 32'hFFFFFFFF, 4'd8);
        v_i = 1'b0;
        cyc();

        exp_q.push_back({4'd7, 32'h0005000F});
        issue(7'h09, 32'h00010003, 32'd5, 4'd7);
        v_i = 1'b0;
        wait_mul("mul1_stall_cycles");
        chk("mul1_wb_cycle", {stall_o, wb_o}, 64'b01);
        cyc();

        exp_q.push_back({4'd8, 32'hFFFFFFEB});
        issue(7'h09, 32'hFFFFFFFD, 32'd7, 4'd8);
        v_i = 1'b0;
        wait_mul("mul2_stall_cycles");
        cyc();

        // ADD held on the inputs across the whole MUL; only the writeback cycle accepts it
        exp_q.push_back({4'd9, 32'd12});
        issue(7'h09, 32'd3, 32'd4, 4'd9);
        exp_q.push_back({4'd2, 32'd2});
        v_i = 1'b1; opecode_i = 7'h00; opr0_i = 1; opr1_i = 1; wb_r_i = 2;
        wait_mul("held_stall_cycles");
        cyc();
        v_i = 1'b0;
        chk("held_add_wb", {stall_o, wb_o, wb_r_o, result_o}, {30'd0, 1'b0, 1'b1, 4'd2, 32'd2});
        cyc();

        issue(7'h09, 32'd6, 32'd7, 4'd10);
        v_i = 1'b0;
        repeat (9) cyc();
        chk("midmul_busy", 64'(stall_o), 64'd1);
        reset = 1'b0;
        cyc();
        chk("abort_outs", {stall_o, wb_o, wb_r_o, result_o}, 64'd0);
        reset = 1'b1;
        repeat (40) cyc();
        chk("abort_idle", {stall_o, wb_o}, 64'd0);

        exp_q.push_back({4'd6, 32'h30});
        issue(7'h00, 32'h10, 32'h20, 4'd6);
        v_i = 1'b0;
        cyc();
        issue(7'h7F, 32'd9, 32'd9, 4'd11);
        chk("nop7f_hold", {stall_o, wb_o, wb_r_o, result_o}, {30'd0, 1'b0, 1'b0, 4'd6, 32'h30});
        issue(7'h0B, 32'd9, 32'd9, 4'd12);
        chk("nop0b_hold", {stall_o, wb_o, wb_r_o, result_o}, {30'd0, 1'b0, 1'b0, 4'd6, 32'h30});
        v_i = 1'b0;
        repeat (3) cyc();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_writeback.md
# execute_writeback

Execute stage of the pipeline that sits after instruction decode. Consumes the decoded opcode, operands and destination register index under the valid/stall handshake, computes the result, and drives the writeback port (`wb`, `wb_r`, `result`) back into the decode stage's register file, which releases the destination reservation. Single-cycle ALU operations complete in one cycle. MUL is a 32-step iterative shift-add that holds the pipeline through `stall_o`.

## Interface
- `WORD`, 32, instruction/data word width
- `W_OPC`, 7, opcode width
- `W_RD`, 4, register index width (16 registers)
- `W_OPR`, 32, operand/result width
- `clk`  in  1  clock. One clock domain; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `v_i`  in  1  valid; the opcode, operands and destination are meaningful this cycle.
- `opecode_i`  in  W_OPC  operation code
- `opr0_i`  in  W_OPR  operand 0 (register value)
- `opr1_i`  in  W_OPR  operand 1 (register value or extended immediate)
- `wb_r_i`  in  W_RD  destination register index
- `stall_o`  out  1  upstream must hold its outputs
- `wb_o`  out  1  writeback strobe, one cycle per completed writing op
- `wb_r_o`  out  W_RD  writeback register index
- `result_o`  out  W_OPR  writeback data

## Operation
- **Opcodes.** All ops write back except where noted.
  - 0x00 ADD: opr0+opr1
  - 0x01 SUB: opr0−opr1
  - 0x02 AND
  - 0x03 OR
  - 0x04 XOR
  - 0x05 SLL: shift amount is opr1[4:0]
  - 0x06 SRL: shift amount is opr1[4:0]
  - 0x07 SRA: shift amount is opr1[4:0]
  - 0x08 MOV: result = opr1
  - 0x09 MUL: low 32 bits of opr0×opr1, multi-cycle
  - 0x0A SLT: signed compare, result 1 if opr0<opr1, else 0
  - 0x0B–0x7F: no writeback, treated as NOP
- **Arithmetic.** Modulo 2^W_OPR; carries and overflow are dropped. MUL low word is identical for signed and unsigned operands.
- **FSM states.** IDLE, BUSY.
  - IDLE, v_i=1, single-cycle op: register result, wb_r_i and wb_o=(writing op). Remain in IDLE.
  - IDLE, v_i=1, MUL: latch multiplicand, multiplier and wb_r_i. Clear accumulator and 5-bit step counter. Go to BUSY. No writeback this edge.
  - BUSY: each cycle, if multiplier[0] then accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - BUSY, counter==31: perform the final step and load result_o with the final accumulator. Set wb_o=1 and wb_r_o to the latched index. Return to IDLE.
  - IDLE, v_i=0: wb_o=0. result_o and wb_r_o hold their values.
- **Stall.** `stall_o` = (state==BUSY), driven combinationally from the state register.
  - While BUSY, v_i and all inputs are ignored; upstream is holding them.
- **Boundary cases.**
  - MUL arriving the cycle after a single-cycle op: accepted normally.
  - An op arriving in the cycle MUL completes (first IDLE cycle) is accepted that cycle.
- **Reset.** reset=0 at a rising edge:
  - state=IDLE; stall_o=0, wb_o=0, wb_r_o=0, result_o=0.
  - Counter and accumulator are cleared.
  - An in-flight MUL is aborted with no writeback.

## Timing
- Single-cycle op accepted at edge N: wb_o=1 with its result during cycle N+1 only.
- MUL accepted at edge N:
  - stall_o=1 during cycles N+1 … N+32.
  - wb_o=1 with the product during cycle N+33.
  - stall_o=0 in cycle N+33, and a new op may be accepted at the end of N+33.
- Back-to-back single-cycle ops: one writeback per cycle, no bubbles.
- wb_o is never high for two consecutive cycles for the same op. It is never high in a cycle where stall_o=1.
- No combinational path from any input to any output. stall_o depends only on state.

## Test plan
- **Reset values.** Hold reset=0 for 3 cycles with v_i=1 and ADD presented. Required: stall_o=0, wb_o=0, wb_r_o=0, result_o=0 throughout.
- **Single-cycle ops, back to back.** ADD 5+7 → r3, then SRA 0x80000000 by 4 → r4, then SLT −1<1 → r5, on consecutive cycles. Required, in the next three cycles: (wb_o=1, r3, 12), (wb_o=1, r4, 0xF8000000), (wb_o=1, r5, 1).
- **MUL.** MUL 0x00010003×5 → r7. Required: stall_o high for exactly 32 cycles, then wb_o=1, wb_r_o=7, result_o=0x0005000F. Repeat with 0xFFFFFFFD×7; required result 0xFFFFFFEB.
- **Op held during MUL.** ADD 1+1 → r2 held on the inputs throughout a MUL. Required: it is accepted only in the MUL writeback cycle, and its writeback (r2, 2) follows in the next cycle. Exactly one writeback per op.
- **Reset mid-MUL.** Assert reset=0 at busy step 10. Required: stall_o=0 and wb_o=0 from the next cycle. No writeback ever occurs for the aborted MUL.
- **NOP opcodes.** Present opcode 0x7F, then 0x0B, with v_i=1. Required: wb_o stays 0, stall_o stays 0, result_o and wb_r_o hold their previous values.
